// File: rtl/mem_arbiter.sv
// Arbitrates one single-port unified memory between fetch and data ports.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants under contention.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_IReq,
  input  logic [ADDR_WIDTH-1:0] i_IAddr,
  output logic                  o_IAck,
  output logic [DATA_WIDTH-1:0] o_IRdata,
  input  logic                  i_DReq,
  input  logic                  i_DWen,
  input  logic [ADDR_WIDTH-1:0] i_DAddr,
  input  logic [DATA_WIDTH-1:0] i_DWd,
  output logic                  o_DAck,
  output logic [DATA_WIDTH-1:0] o_DRd,
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic                  o_MRen,
  output logic                  o_MWen,
  output logic [DATA_WIDTH-1:0] o_MWd,
  input  logic [DATA_WIDTH-1:0] i_MRd,
  output logic                  o_Busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_own_d;
  logic                  r_wen;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_maddr;
  logic [DATA_WIDTH-1:0] r_mwd;
  logic [DATA_WIDTH-1:0] r_irdata;
  logic [DATA_WIDTH-1:0] r_drd;
  logic                  w_any;
  logic                  w_grant_d;
  logic                  w_grant;

  assign w_any   = i_IReq | i_DReq;
  assign w_grant = (r_state == S_IDLE) && w_any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = data port won the most recent grant
  logic r_last_d;

  assign w_grant_d = (i_IReq && i_DReq) ? ~r_last_d : i_DReq;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_last_d <= 1'b0;
    end else if (w_grant) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = i_DReq;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    o_MRen = 1'b0;
    o_MWen = 1'b0;
    o_IAck = 1'b0;
    o_DAck = 1'b0;
    o_Busy = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        o_Busy = 1'b0;
        if (w_any) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        o_MRen = ~r_wen;
        o_MWen = r_wen;
        w_next = r_wen ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_RESP;
      end
      S_RESP: begin
        o_IAck = ~r_own_d;
        o_DAck = r_own_d;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are captured only at the grant edge
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_own_d  <= 1'b0;
      r_wen    <= 1'b0;
      r_cnt    <= 4'd0;
      r_maddr  <= '0;
      r_mwd    <= '0;
      r_irdata <= '0;
      r_drd    <= '0;
    end else begin
      if (w_grant) begin
        r_own_d <= w_grant_d;
        r_wen   <= w_grant_d & i_DWen;
        r_maddr <= w_grant_d ? i_DAddr : i_IAddr;
        r_mwd   <= w_grant_d ? i_DWd : '0;
      end
      if (r_state == S_ISSUE && !r_wen) begin
        r_cnt <= LAT_M1;
      end
      if (r_state == S_WAIT) begin
        if (r_cnt == 4'd0) begin
          if (r_own_d) r_drd <= i_MRd;
          else r_irdata <= i_MRd;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign o_MAddr  = r_maddr;
  assign o_MWd    = r_mwd;
  assign o_IRdata = r_irdata;
  assign o_DRd    = r_drd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances at latencies 1, 3 and 15
// sharing one memory model that returns data only in the latency cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn  [3];
  logic        ireq  [3];
  logic        dreq  [3];
  logic        dwen  [3];
  logic [31:0] iaddr [3];
  logic [31:0] daddr [3];
  logic [31:0] dwd   [3];
  logic [31:0] mrd   [3];
  logic        iack  [3];
  logic        dack  [3];
  logic [31:0] irdata[3];
  logic [31:0] drd   [3];
  logic [31:0] maddr [3];
  logic        mren  [3];
  logic        mwen  [3];
  logic [31:0] mwd   [3];
  logic        busy  [3];

  int checks = 0;
  int errors = 0;
  int cyc;
  bit ovl = 1'b0;

  bit [31:0]  wmem  [256];
  bit [255:0] wvalid;
  bit [3:0]   rc    [3];
  bit [31:0]  ra    [3];

  always #5 clk = ~clk;

  function automatic bit [3:0] lat(input int k);
    return (k == 0) ? 4'd1 : ((k == 1) ? 4'd3 : 4'd15);
  endfunction

  function automatic logic [31:0] rdw(input logic [7:0] a);
    if (wvalid[a]) return wmem[a];
    case (a)
      8'h00:   return 32'hA0A0A0A0;
      8'h01:   return 32'hB1B1B1B1;
      8'h04:   return 32'h00500093;
      8'h20:   return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mren[k] === 1'b1) begin
        rc[k] <= lat(k);
        ra[k] <= maddr[k];
      end else if (rc[k] != 4'd0) begin
        rc[k] <= rc[k] - 4'd1;
      end
      if (mwen[k] === 1'b1) begin
        wmem[maddr[k][9:2]]   <= mwd[k];
        wvalid[maddr[k][9:2]] <= 1'b1;
      end
      if (mren[k] === 1'b1 && mwen[k] === 1'b1) ovl <= 1'b1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign mrd[g] = (rc[g] == 4'd1) ? rdw(ra[g][9:2]) : 32'hBAD0BAD0;

    mem_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 15))
    ) u_dut (
      .i_clk   (clk),
      .i_rstn  (rstn[g]),
      .i_IReq  (ireq[g]),
      .i_IAddr (iaddr[g]),
      .o_IAck  (iack[g]),
      .o_IRdata(irdata[g]),
      .i_DReq  (dreq[g]),
      .i_DWen  (dwen[g]),
      .i_DAddr (daddr[g]),
      .i_DWd   (dwd[g]),
      .o_DAck  (dack[g]),
      .o_DRd   (drd[g]),
      .o_MAddr (maddr[g]),
      .o_MRen  (mren[g]),
      .o_MWen  (mwen[g]),
      .o_MWd   (mwd[g]),
      .i_MRd   (mrd[g]),
      .o_Busy  (busy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle index of the first ack seen, or -1 on timeout
  task automatic wait_ack(input int k, input bit d, input int start,
                          output int c);
    bit done;
    done = 1'b0;
    c = -1;
    for (int n = start; n < start + 60 && !done; n++) begin
      if ((d ? dack[k] : iack[k]) === 1'b1) begin
        c = n;
        done = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) rstn[k] = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy[k] !== 1'b0 || mren[k] !== 1'b0 || mwen[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctl[%0d] busy=%b mren=%b mwen=%b want 0 0 0",
                 k, busy[k], mren[k], mwen[k]);
      end
      checks++;
      if (iack[k] !== 1'b0 || dack[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ack[%0d] iack=%b dack=%b want 0 0",
                 k, iack[k], dack[k]);
      end
      checks++;
      if (maddr[k] !== 32'h0 || mwd[k] !== 32'h0 ||
          irdata[k] !== 32'h0 || drd[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_data[%0d] maddr=%h mwd=%h ir=%h dr=%h want 0",
                 k, maddr[k], mwd[k], irdata[k], drd[k]);
      end
    end
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
    tick();
  endtask

  task automatic test_fetch(input int k, input int exp_cyc);
    iaddr[k] = 32'h10;
    ireq[k]  = 1'b1;
    tick();
    checks++;
    if (mren[k] !== 1'b1 || mwen[k] !== 1'b0 || maddr[k] !== 32'h10) begin
      errors++;
      $display("FAIL fetch_issue[%0d] mren=%b mwen=%b maddr=%h want 1 0 10",
               k, mren[k], mwen[k], maddr[k]);
    end
    wait_ack(k, 1'b0, 1, cyc);
    ireq[k] = 1'b0;
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL fetch_lat[%0d] got %0d want %0d", k, cyc, exp_cyc);
    end
    checks++;
    if (irdata[k] !== 32'h00500093 || drd[k] !== 32'h0) begin
      errors++;
      $display("FAIL fetch_data[%0d] ir=%h dr=%h want 00500093 0",
               k, irdata[k], drd[k]);
    end
    tick();
  endtask

  task automatic test_store_load();
    daddr[1] = 32'h40;
    dwd[1]   = 32'hDEADBEEF;
    dwen[1]  = 1'b1;
    dreq[1]  = 1'b1;
    tick();
    checks++;
    if (mwen[1] !== 1'b1 || mren[1] !== 1'b0 ||
        maddr[1] !== 32'h40 || mwd[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_issue mwen=%b mren=%b maddr=%h mwd=%h",
               mwen[1], mren[1], maddr[1], mwd[1]);
    end
    wait_ack(1, 1'b1, 1, cyc);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL store_lat got %0d want 2", cyc);
    end
    dwen[1] = 1'b0;
    tick();
    checks++;
    if (busy[1] !== 1'b0 || dack[1] !== 1'b0) begin
      errors++;
      $display("FAIL gap_idle busy=%b dack=%b want 0 0", busy[1], dack[1]);
    end
    tick();
    checks++;
    if (mren[1] !== 1'b1 || mwen[1] !== 1'b0 || maddr[1] !== 32'h40) begin
      errors++;
      $display("FAIL load_issue mren=%b mwen=%b maddr=%h",
               mren[1], mwen[1], maddr[1]);
    end
    wait_ack(1, 1'b1, 1, cyc);
    dreq[1] = 1'b0;
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL load_lat got %0d want 5", cyc);
    end
    checks++;
    if (drd[1] !== 32'hDEADBEEF || irdata[1] !== 32'h00500093) begin
      errors++;
      $display("FAIL load_data dr=%h ir=%h want deadbeef 00500093",
               drd[1], irdata[1]);
    end
    tick();
  endtask

  task automatic test_contention();
    bit rr;
    bit exp_i;
    bit exp_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    iaddr[0] = 32'h10;
    daddr[0] = 32'h40;
    dwen[0]  = 1'b0;
    ireq[0]  = 1'b1;
    dreq[0]  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      exp_d = (c % 4 == 3) && (!rr || ((c / 4) % 2 == 0));
      exp_i = (c % 4 == 3) && rr && ((c / 4) % 2 == 1);
      checks++;
      if (dack[0] !== exp_d || iack[0] !== exp_i) begin
        errors++;
        $display("FAIL contend_c%0d dack=%b iack=%b want %b %b",
                 c, dack[0], iack[0], exp_d, exp_i);
      end
      if (c < 15) tick();
    end
    ireq[0] = 1'b0;
    dreq[0] = 1'b0;
    checks++;
    if (drd[0] !== 32'hDEADBEEF || irdata[0] !== 32'h00500093) begin
      errors++;
      $display("FAIL contend_data dr=%h ir=%h want deadbeef 00500093",
               drd[0], irdata[0]);
    end
    tick();
  endtask

  task automatic test_reset_wait();
    daddr[1] = 32'h80;
    dwen[1]  = 1'b0;
    dreq[1]  = 1'b1;
    tick();
    tick();
    rstn[1] = 1'b0;
    tick();
    checks++;
    if (busy[1] !== 1'b0 || dack[1] !== 1'b0 || mren[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_ctl busy=%b dack=%b mren=%b want 0 0 0",
               busy[1], dack[1], mren[1]);
    end
    checks++;
    if (drd[1] !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait_drd got %h want 0", drd[1]);
    end
    rstn[1] = 1'b1;
    tick();
    checks++;
    if (mren[1] !== 1'b1 || maddr[1] !== 32'h80) begin
      errors++;
      $display("FAIL reissue_issue mren=%b maddr=%h want 1 80",
               mren[1], maddr[1]);
    end
    wait_ack(1, 1'b1, 1, cyc);
    dreq[1] = 1'b0;
    checks++;
    if (cyc !== 5 || drd[1] !== 32'h12345678) begin
      errors++;
      $display("FAIL reissue_load cyc=%0d dr=%h want 5 12345678",
               cyc, drd[1]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    iaddr[2] = 32'h0;
    ireq[2]  = 1'b1;
    tick();
    wait_ack(2, 1'b0, 1, cyc);
    checks++;
    if (cyc !== 17 || irdata[2] !== 32'hA0A0A0A0) begin
      errors++;
      $display("FAIL b2b_first cyc=%0d ir=%h want 17 a0a0a0a0",
               cyc, irdata[2]);
    end
    iaddr[2] = 32'h4;
    tick();
    wait_ack(2, 1'b0, 18, cyc);
    ireq[2] = 1'b0;
    checks++;
    if (cyc !== 35 || irdata[2] !== 32'hB1B1B1B1) begin
      errors++;
      $display("FAIL b2b_second cyc=%0d ir=%h want 35 b1b1b1b1",
               cyc, irdata[2]);
    end
    checks++;
    if (ovl !== 1'b0) begin
      errors++;
      $display("FAIL strobe_overlap got %b want 0", ovl);
    end
    tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstn[k]  = 1'b0;
      ireq[k]  = 1'b0;
      dreq[k]  = 1'b0;
      dwen[k]  = 1'b0;
      iaddr[k] = 32'h0;
      daddr[k] = 32'h0;
      dwd[k]   = 32'h0;
    end
    test_reset();
    test_fetch(0, 3);
    test_fetch(1, 5);
    test_store_load();
    test_contention();
    test_reset_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
